// File: rtl/apb_i2c_bus_arbiter.sv
// Round-robin arbiter that shares one APB master port among NUM_REQ requesters.
// It sequences SETUP/ACCESS, returns read data and error status, and aborts stalled transfers.
module apb_i2c_bus_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int APB_ADDR_WIDTH = 12,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                              HCLK,
  input  logic                              HRESET,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ-1:0]                req_write,
  input  logic [NUM_REQ*APB_ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*32-1:0]             req_wdata,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic [NUM_REQ-1:0]                rsp_valid,
  output logic [31:0]                       rsp_rdata,
  output logic                              rsp_err,
  output logic                              busy_o,
  output logic                              PSEL,
  output logic                              PENABLE,
  output logic                              PWRITE,
  output logic [APB_ADDR_WIDTH-1:0]         PADDR,
  output logic [31:0]                       PWDATA,
  input  logic [31:0]                       PRDATA,
  input  logic                              PREADY,
  input  logic                              PSLVERR
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [IDX_W:0]       NREQ_V   = (IDX_W + 1)'(NUM_REQ);
  localparam logic [CNT_W-1:0]     TO_V     = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]     CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [NUM_REQ-1:0]   ONE_HOT0 = NUM_REQ'(1);
  localparam logic                 TO_EN    = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic [IDX_W-1:0]          rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]          win_q, win_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      psel_q, psel_d;
  logic                      penable_q, penable_d;
  logic                      pwrite_q, pwrite_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [31:0]               pwdata_q, pwdata_d;
  logic [NUM_REQ-1:0]        rsp_valid_q, rsp_valid_d;
  logic [31:0]               rsp_rdata_q, rsp_rdata_d;
  logic                      rsp_err_q, rsp_err_d;
  logic                      busy_q, busy_d;

  logic [APB_ADDR_WIDTH-1:0] addr_arr_s [NUM_REQ];
  logic [31:0]               wdata_arr_s [NUM_REQ];
  logic [IDX_W:0]            cand_s;
  logic [IDX_W:0]            rr_sum_s;
  logic [IDX_W-1:0]          win_s;
  logic [IDX_W-1:0]          rr_nxt_s;
  logic                      grant_s;
  logic                      arb_en_s;
  logic                      accept_s;
  logic                      timeout_hit_s;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr_s[g]  = req_addr[g*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
    assign wdata_arr_s[g] = req_wdata[g*32 +: 32];
  end

  // Round-robin search: first valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    grant_s  = 1'b0;
    win_s    = '0;
    cand_s   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_s = {1'b0, rr_ptr_q} + (IDX_W + 1)'(i);
      cand_s = (cand_s >= NREQ_V) ? (cand_s - NREQ_V) : cand_s;
      if (!grant_s && req_valid[cand_s[IDX_W-1:0]]) begin
        grant_s = 1'b1;
        win_s   = cand_s[IDX_W-1:0];
      end else begin
        win_s   = win_s;
      end
    end
    rr_sum_s      = {1'b0, win_s} + (IDX_W + 1)'(1);
    rr_nxt_s      = (rr_sum_s >= NREQ_V) ? '0 : rr_sum_s[IDX_W-1:0];
    arb_en_s      = (state_q == ST_IDLE) && !HRESET;
    accept_s      = arb_en_s && grant_s;
    timeout_hit_s = TO_EN && (cnt_q == TO_V);
    req_ready     = accept_s ? (ONE_HOT0 << win_s) : '0;
  end

  // State register and all datapath flops.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      win_q       <= '0;
      cnt_q       <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= 32'h0000_0000;
      rsp_valid_q <= '0;
      rsp_rdata_q <= 32'h0000_0000;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      win_q       <= win_d;
      cnt_q       <= cnt_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state logic; PREADY only matters in ACCESS.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = ST_SETUP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (PREADY || timeout_hit_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ACCESS;
        end
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values; APB controls follow the next state so they are registered.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    win_d       = win_q;
    cnt_d       = cnt_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    psel_d      = (state_d != ST_IDLE);
    penable_d   = (state_d == ST_ACCESS);
    busy_d      = (state_d != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          pwrite_d = req_write[win_s];
          paddr_d  = addr_arr_s[win_s];
          pwdata_d = wdata_arr_s[win_s];
          win_d    = win_s;
          rr_ptr_d = rr_nxt_s;
          cnt_d    = '0;
        end else begin
          cnt_d    = cnt_q;
        end
      end
      ST_SETUP: begin
        cnt_d = '0;
      end
      ST_ACCESS: begin
        if (PREADY) begin
          rsp_valid_d = ONE_HOT0 << win_q;
          rsp_rdata_d = pwrite_q ? 32'h0000_0000 : PRDATA;
          rsp_err_d   = PSLVERR;
        end else if (timeout_hit_s) begin
          rsp_valid_d = ONE_HOT0 << win_q;
          rsp_rdata_d = 32'h0000_0000;
          rsp_err_d   = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        rsp_valid_d = '0;
      end
    endcase
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign busy_o    = busy_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;

endmodule

// File: tb/tb_apb_i2c_bus_arbiter.sv
// Scenario-driven bench for apb_i2c_bus_arbiter (3 requesters, timeout 4).
// Responses are predicted at accept time into a queue and checked by a response monitor.
module tb_apb_i2c_bus_arbiter;

  localparam int N  = 3;
  localparam int AW = 12;
  localparam int TO = 4;

  logic          HCLK = 1'b0;
  logic          HRESET;
  logic [N-1:0]  req_valid, req_write, req_ready, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*32-1:0] req_wdata;
  logic [31:0]   rsp_rdata, PWDATA, PRDATA;
  logic          rsp_err, busy_o, PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [AW-1:0] PADDR;

  typedef struct {
    int          idx;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   model_ptr = 0;

  apb_i2c_bus_arbiter #(.NUM_REQ(N), .APB_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .busy_o(busy_o), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 HCLK = ~HCLK;

  function automatic logic [N-1:0] oh(input int i);
    oh = 3'b001 << i;
  endfunction

  task automatic tick();
    @(posedge HCLK);
    #2;
  endtask

  // Response monitor: pops the scoreboard on every completion pulse.
  always @(negedge HCLK) begin
    if (!HRESET && rsp_valid != '0) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: rsp_valid=%b required none", rsp_valid);
      end else begin
        mon_e = sb.pop_front();
        if (rsp_valid !== oh(mon_e.idx)) begin
          errors++;
          $display("FAIL rsp_valid: got %b required %b", rsp_valid, oh(mon_e.idx));
        end
        checks++;
        if (rsp_rdata !== mon_e.rdata) begin
          errors++;
          $display("FAIL rsp_rdata: got %h required %h", rsp_rdata, mon_e.rdata);
        end
        checks++;
        if (rsp_err !== mon_e.err) begin
          errors++;
          $display("FAIL rsp_err: got %b required %b", rsp_err, mon_e.err);
        end
      end
    end
  end

  task automatic do_xfer(input int idx, input bit wr, input logic [AW-1:0] addr,
                         input logic [31:0] wdata, input int waits, input logic [31:0] rdata,
                         input bit err, input bit to);
    exp_t e;
    int   n_acc;
    req_write[idx]          = wr;
    req_addr[idx*AW +: AW]  = addr;
    req_wdata[idx*32 +: 32] = wdata;
    req_valid[idx]          = 1'b1;
    #1;
    checks++;
    if (req_ready !== oh(idx)) begin
      errors++;
      $display("FAIL accept_ready: got %b required %b", req_ready, oh(idx));
    end
    e.idx   = idx;
    e.rdata = (wr || to) ? 32'h0000_0000 : rdata;
    e.err   = to ? 1'b1 : err;
    sb.push_back(e);
    model_ptr = (idx + 1) % N;
    tick();
    req_valid[idx] = 1'b0;
    checks++;
    if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, busy_o} !== {1'b1, 1'b0, wr, addr, wdata, 1'b1}) begin
      errors++;
      $display("FAIL setup_phase: got sel=%b en=%b wr=%b addr=%h wdata=%h busy=%b required 1 0 %b %h %h 1",
               PSEL, PENABLE, PWRITE, PADDR, PWDATA, busy_o, wr, addr, wdata);
    end
    n_acc = to ? TO + 1 : waits + 1;
    for (int a = 0; a < n_acc; a++) begin
      tick();
      checks++;
      if ({PSEL, PENABLE, rsp_valid} !== {2'b11, 3'b000}) begin
        errors++;
        $display("FAIL access_phase: cycle %0d sel=%b en=%b rsp_valid=%b required 1 1 000",
                 a, PSEL, PENABLE, rsp_valid);
      end
      PREADY  = !to && (a == n_acc - 1);
      PSLVERR = (a == n_acc - 1) ? err : 1'b1;
      PRDATA  = rdata;
    end
    tick();
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
    checks++;
    if ({rsp_valid, busy_o, PSEL, PENABLE} !== {oh(idx), 3'b000}) begin
      errors++;
      $display("FAIL completion: rsp_valid=%b busy=%b sel=%b en=%b required %b 0 0 0",
               rsp_valid, busy_o, PSEL, PENABLE, oh(idx));
    end
  endtask

  task automatic test_reset();
    HRESET = 1'b1;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    PRDATA = 32'h0000_0000; PREADY = 1'b0; PSLVERR = 1'b0;
    repeat (3) tick();
    checks++;
    if ({rsp_valid, rsp_rdata, rsp_err, busy_o, PSEL, PENABLE, PWRITE, PADDR, PWDATA, req_ready} !== '0) begin
      errors++;
      $display("FAIL reset_values: rsp_valid=%b rdata=%h err=%b busy=%b sel=%b en=%b wr=%b addr=%h wdata=%h ready=%b required all 0",
               rsp_valid, rsp_rdata, rsp_err, busy_o, PSEL, PENABLE, PWRITE, PADDR, PWDATA, req_ready);
    end
    HRESET = 1'b0;
    model_ptr = 0;
    tick();
  endtask

  task automatic test_round_robin();
    exp_t e;
    int n_acc = 0, last_cyc = 0, cyc = 0, exp_w = model_ptr, prev_w = -1, k = 0;
    for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = 12'h100 + AW'(i);
    req_write = '0;
    PRDATA = 32'h5A5A_0000; PREADY = 1'b1; PSLVERR = 1'b0;
    req_valid = 3'b111;
    while (n_acc < 6 && cyc < 40) begin
      #1;
      if (req_ready != '0) begin
        checks++;
        if (req_ready !== oh(exp_w)) begin
          errors++;
          $display("FAIL rr_grant: accept %0d got %b required %b", n_acc, req_ready, oh(exp_w));
        end
        if (n_acc > 0) begin
          checks++;
          if (cyc - last_cyc != 3) begin
            errors++;
            $display("FAIL rr_spacing: got %0d cycles required 3", cyc - last_cyc);
          end
        end
        e.idx = exp_w; e.rdata = 32'h5A5A_0000; e.err = 1'b0;
        sb.push_back(e);
        prev_w = exp_w;
        last_cyc = cyc;
        n_acc++;
        exp_w = (exp_w + 1) % N;
      end
      tick();
      cyc++;
      if (n_acc == 6) req_valid = '0;
      if (prev_w >= 0 && last_cyc == cyc - 1) begin
        checks++;
        if (PADDR !== 12'h100 + AW'(prev_w)) begin
          errors++;
          $display("FAIL rr_paddr: got %h required %h", PADDR, 12'h100 + AW'(prev_w));
        end
      end
    end
    checks++;
    if (n_acc != 6) begin
      errors++;
      $display("FAIL rr_accepts: got %0d required 6", n_acc);
    end
    while (sb.size() != 0 && k < 20) begin
      tick();
      k++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL rr_drain: %0d responses outstanding required 0", sb.size());
    end
    PREADY = 1'b0;
    req_valid = '0;
    model_ptr = exp_w;
    tick();
  endtask

  task automatic test_single_write();
    do_xfer(0, 1'b1, 12'h010, 32'hA5A5_0001, 0, 32'hDEAD_BEEF, 1'b0, 1'b0);
  endtask

  task automatic test_wait_read();
    do_xfer(1, 1'b0, 12'h004, 32'h0000_0000, 3, 32'h0000_00C3, 1'b0, 1'b0);
  endtask

  task automatic test_slave_err();
    do_xfer(0, 1'b1, 12'h030, 32'h1111_2222, 0, 32'h0000_0000, 1'b1, 1'b0);
    do_xfer(2, 1'b0, 12'h034, 32'h0000_0000, 1, 32'h3333_4444, 1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    do_xfer(2, 1'b0, 12'h040, 32'h0000_0000, 0, 32'hFFFF_0000, 1'b0, 1'b1);
    do_xfer(1, 1'b0, 12'h044, 32'h0000_0000, 0, 32'h0000_0099, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_xfer(0, 1'b0, 12'h050, 32'h0000_0000, 0, 32'h0BAD_F00D, 1'b0, 1'b0);
    do_xfer(2, 1'b1, 12'h054, 32'h7654_3210, 2, 32'h1234_5678, 1'b0, 1'b0);
    do_xfer(1, 1'b0, 12'h058, 32'h0000_0000, 0, 32'h8000_0001, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_access();
    req_write[0] = 1'b0;
    req_addr[0 +: AW] = 12'h060;
    req_valid = 3'b001;
    #1;
    tick();
    req_valid = '0;
    PREADY = 1'b0;
    repeat (3) tick();
    #1;
    HRESET = 1'b1;
    #1;
    checks++;
    if ({PSEL, PENABLE, busy_o, rsp_valid} !== 6'b000000) begin
      errors++;
      $display("FAIL reset_abort: sel=%b en=%b busy=%b rsp_valid=%b required all 0",
               PSEL, PENABLE, busy_o, rsp_valid);
    end
    tick();
    HRESET = 1'b0;
    model_ptr = 0;
    req_addr[0 +: AW] = 12'h070;
    req_addr[AW +: AW] = 12'h074;
    req_valid = 3'b011;
    #1;
    checks++;
    if (req_ready !== oh(model_ptr)) begin
      errors++;
      $display("FAIL reset_rr_ptr: got %b required %b", req_ready, oh(model_ptr));
    end
    req_valid = '0;
    tick();
    do_xfer(1, 1'b0, 12'h020, 32'h0000_0000, 0, 32'h0000_7777, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_write();
    test_wait_read();
    test_slave_err();
    test_timeout();
    test_back_to_back();
    test_reset_mid_access();
    repeat (5) tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL final_drain: %0d responses outstanding required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/apb_i2c_bus_arbiter.md
# apb_i2c_bus_arbiter

Round-robin arbiter and APB master sequencer that lets several on-chip requesters share the single APB port of the APB-to-I2C controller. It accepts one command at a time from NUM_REQ requesters and drives the APB SETUP/ACCESS protocol toward the I2C slave. It returns read data and error status to the winning requester and aborts transfers whose PREADY never arrives.

## Interface
- NUM_REQ, 2: number of requesters (2..8).
- APB_ADDR_WIDTH, 12: APB address width.
- TIMEOUT_CYCLES, 255: maximum ACCESS cycles waiting for PREADY; 0 disables the timeout.
- HCLK  in  1  clock. Single clock domain; all logic is rising-edge.
- HRESET  in  1  reset, asynchronous, active-high.
- req_valid  in  NUM_REQ  command pending, one bit per requester.
- req_write  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*APB_ADDR_WIDTH  flattened addresses; requester i occupies slice [i*APB_ADDR_WIDTH +: APB_ADDR_WIDTH].
- req_wdata  in  NUM_REQ*32  flattened write data; requester i occupies slice [i*32 +: 32].
- req_ready  out  NUM_REQ  one-hot accept pulse.
- rsp_valid  out  NUM_REQ  one-hot completion pulse.
- rsp_rdata  out  32  read data, valid with rsp_valid.
- rsp_err  out  1  PSLVERR or timeout, valid with rsp_valid.
- busy_o  out  1  transfer in flight (state != IDLE).
- PSEL, PENABLE, PWRITE  out  1  APB master controls.
- PADDR  out  APB_ADDR_WIDTH  APB address.
- PWDATA  out  32  APB write data.
- PRDATA  in  32  APB read data.
- PREADY, PSLVERR  in  1  APB slave response.

## Operation
- FSM has three states: IDLE, SETUP, ACCESS.
- IDLE:
  - If any req_valid is set, pick the winner by round robin, starting the search at pointer rr_ptr.
  - Assert req_ready[winner] in the same cycle (combinational from req_valid and rr_ptr).
  - Capture write, address and wdata into PWRITE/PADDR/PWDATA registers.
  - Store the winner index, set rr_ptr = (winner+1) mod NUM_REQ, go to SETUP.
- A requester must hold its command stable while req_valid=1 and it has not yet seen req_ready.
- SETUP: PSEL=1, PENABLE=0. Unconditionally go to ACCESS.
- ACCESS: PSEL=1, PENABLE=1. Increment the wait counter on every cycle PREADY=0.
  - If PREADY=1: register rsp_rdata = PRDATA when the transfer is a read, otherwise 0. Register rsp_err = PSLVERR. Pulse rsp_valid[winner] next cycle. Go to IDLE.
  - Else, if TIMEOUT_CYCLES != 0 and the counter equals TIMEOUT_CYCLES: set rsp_err = 1, rsp_rdata = 0, pulse rsp_valid[winner], go to IDLE.
- PREADY and PSLVERR are ignored outside ACCESS.
- Wait counter: width clog2(TIMEOUT_CYCLES+1), minimum 1 bit. Cleared on entering SETUP. Saturates and never wraps.
- PADDR, PWDATA and PWRITE hold their last values in IDLE.
- rsp_rdata and rsp_err hold their values until the next completion.

## Timing
- Reset values: state IDLE, rr_ptr 0, PSEL 0, PENABLE 0, PWRITE 0, PADDR 0, PWDATA 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, busy_o 0, counter 0. req_ready is 0 whenever req_valid is 0.
- Zero-wait transfer, with accept in cycle 0:
  - cycle 0: IDLE, req_ready=1.
  - cycle 1: SETUP.
  - cycle 2: ACCESS, PREADY=1.
  - cycle 3: rsp_valid=1 and state IDLE; a new accept may occur in this same cycle 3.
- Best case is one transfer every 3 cycles.
- Each PREADY=0 cycle in ACCESS adds one cycle of latency.
- The timeout fires on the ACCESS cycle where the count reaches TIMEOUT_CYCLES, i.e. TIMEOUT_CYCLES+1 ACCESS cycles in total. PSEL and PENABLE are 0 on the following cycle.
- A requester may raise req_valid in the cycle it receives rsp_valid; that request is eligible immediately.
- Simultaneous requests: exactly one req_ready bit is set. The others wait with no starvation; the worst-case wait is NUM_REQ-1 transfers.
- A requester dropping req_valid before it is accepted is legal; it is simply not granted.
- HRESET asserted mid-transfer: all outputs return to reset values immediately (asynchronously). No rsp_valid is issued for the aborted transfer. The winner must reissue its command.

## Test plan
- Single write, zero-wait: req0 writes addr 0x010, data 0xA5A5_0001 -> PSEL in cycles 1-2, PENABLE in cycle 2 only, PADDR=0x010, PWDATA=0xA5A5_0001, rsp_valid[0] in cycle 3 with rsp_err=0.
- Read with 3 wait states: req1 reads addr 0x004, PREADY low for 3 ACCESS cycles, PRDATA=0x0000_00C3 -> rsp_valid[1] in cycle 6, rsp_rdata=0x0000_00C3.
- Round robin: NUM_REQ=3, all req_valid held high for 6 transfers -> grant order 0,1,2,0,1,2, with one accept every 3 cycles.
- Slave error: PSLVERR=1 together with PREADY -> rsp_err=1; the next transfer reports rsp_err=0.
- Timeout: TIMEOUT_CYCLES=4, PREADY stuck at 0 -> 5 ACCESS cycles, then rsp_valid with rsp_err=1, rsp_rdata=0, and busy_o=0 the next cycle.
- Reset mid-ACCESS: assert HRESET during wait states -> PSEL=0, PENABLE=0, rr_ptr=0, no rsp_valid; after release, req1 alone is granted normally.
